// File: rtl/calc_result_display.sv
// Result display stage: captures the multiplier's sign-magnitude result and drives a
// time-multiplexed 3-digit common-anode display (sign, tens, units). Macro: LEAD_ZERO_BLANK_EN.
module calc_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_result,
  input  logic       in_zero,
  input  logic       in_negative,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       disp_valid,
  output logic [1:0] cur_digit
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    DIG_UNITS = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_SIGN  = 2'd2
  } digit_t;

  logic [CW-1:0] refresh_cnt;
  logic          wrap;
  digit_t        digit_sel;
  digit_t        digit_next;
  logic [3:0]    mag_q;
  logic          neg_q;
  logic          zero_q;
  logic          tens;
  logic [3:0]    units;
  logic [6:0]    seg_next;
  logic [2:0]    an_next;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // "-0" is suppressed at capture time: a zero result never carries the sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q      <= 4'd0;
      neg_q      <= 1'b0;
      zero_q     <= 1'b0;
      disp_valid <= 1'b0;
    end else if (in_valid) begin
      mag_q      <= in_result[3:0];
      neg_q      <= in_negative & ~in_zero;
      zero_q     <= in_zero;
      disp_valid <= 1'b1;
    end
  end

  assign wrap = (refresh_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_sel   <= DIG_UNITS;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      digit_sel   <= digit_next;
    end
  end

  // Illegal encoding 3 recovers to units on the next edge regardless of the counter
  always_comb begin
    digit_next = DIG_UNITS;
    case (digit_sel)
      DIG_UNITS: digit_next = wrap ? DIG_TENS  : DIG_UNITS;
      DIG_TENS:  digit_next = wrap ? DIG_SIGN  : DIG_TENS;
      DIG_SIGN:  digit_next = wrap ? DIG_UNITS : DIG_SIGN;
      default:   digit_next = DIG_UNITS;
    endcase
  end

  assign tens  = (mag_q >= 4'd10);
  assign units = tens ? (mag_q - 4'd10) : mag_q;

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 3'b111;
    if (disp_valid) begin
      an_next = ~(3'b001 << digit_sel);
      case (digit_sel)
        DIG_UNITS: seg_next = glyph(units);
`ifdef LEAD_ZERO_BLANK_EN
        DIG_TENS:  seg_next = tens ? glyph(4'd1) : SEG_BLANK;
`else
        DIG_TENS:  seg_next = glyph({3'd0, tens});
`endif
        DIG_SIGN:  seg_next = (neg_q & ~zero_q) ? SEG_MINUS : SEG_BLANK;
        default:   seg_next = SEG_BLANK;
      endcase
    end else begin
      seg_next = SEG_BLANK;
      an_next  = 3'b111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n     <= SEG_BLANK;
      an_n      <= 3'b111;
      cur_digit <= 2'd0;
    end else begin
      seg_n     <= seg_next;
      an_n      <= an_next;
      cur_digit <= digit_sel;
    end
  end

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Downstream consumer of the sign-magnitude multiplier stage in the logic calculator.
- Captures the 5-bit result (bit 4 = sign, bits 3:0 = magnitude) plus zero/negative flags on a valid strobe.
- Converts the magnitude to decimal and drives a time-multiplexed 3-digit common-anode 7-segment display: sign, tens, units.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays lit before advancing to the next; legal range 2..2^20.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  one-cycle strobe; capture in_result/in_zero/in_negative
- in_result  input  5  bit 4 = sign, bits 3:0 = unsigned magnitude 0..15
- in_zero  input  1  zero flag from the multiplier
- in_negative  input  1  negative flag from the multiplier
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_n  output  3  digit enables, active-low; bit 0 = units, bit 1 = tens, bit 2 = sign
- disp_valid  output  1  high once at least one value has been captured since reset
- cur_digit  output  2  index of the digit currently driven (0,1,2)

Behaviour:
- Reset (async, active-high). Captured magnitude, sign and zero are cleared. refresh_cnt = 0, digit_sel = 0, disp_valid = 0, seg_n = 7'h7F, an_n = 3'b111, cur_digit = 0.
- Capture. On a rising clk edge with in_valid = 1:
  - mag_q <= in_result[3:0]
  - neg_q <= in_negative & ~in_zero, which suppresses "-0"
  - zero_q <= in_zero
  - disp_valid <= 1
  - in_valid = 0 holds all captured values.
  - in_result[4] is ignored; in_negative is authoritative.
- Decimal split, combinational from mag_q:
  - tens = 1 if mag_q >= 10, else 0
  - units = mag_q - 10*tens
- Refresh counter:
  - refresh_cnt counts 0..REFRESH_DIV-1.
  - When refresh_cnt = REFRESH_DIV-1 it wraps to 0, and digit_sel advances 0->1->2->0.
  - digit_sel never takes the value 3. If it ever reads 3, the next edge forces it to 0.
- Digit FSM. States are DIG_UNITS(0), DIG_TENS(1), DIG_SIGN(2). Transitions happen only on counter wrap.
- Output register. seg_n, an_n and cur_digit are registered from digit_sel and the captured state.
  - Latency: a capture at edge N becomes visible on seg_n at edge N+1, while the relevant digit is selected.
  - While disp_valid = 0: an_n = 3'b111 and seg_n = 7'h7F.
  - While disp_valid = 1: an_n = ~(3'b001 << digit_sel).
- Segment encoding (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - minus = 3F
  - blank = 7F
- Per-digit content:
  - Units digit: units glyph.
  - Tens digit: tens glyph (0 or 1).
  - Sign digit: minus if neg_q, else blank.
- Simultaneous capture and digit advance: both take effect on the same edge. The next edge shows the new value on the new digit.
- Back-to-back in_valid: every strobe captures; the last one wins.
- Reset asserted mid-frame: outputs blank immediately (async), not at the next edge.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN
- Defined: the tens digit shows blank (7F) when tens = 0, so the display reads e.g. " -5" instead of "-05".
- Undefined: the tens digit always shows its glyph, so "0" appears for magnitudes below 10.
- The units digit is never blanked while disp_valid = 1.

Test Plan:
- Reset then idle 20 cycles, REFRESH_DIV=4 -> an_n=111, seg_n=7F, disp_valid=0 throughout; digit_sel still cycles (cur_digit pattern 0,0,0,0,1,...).
- in_valid with in_result=5'b1_1001, in_negative=1, in_zero=0, REFRESH_DIV=4 -> expected outputs per digit:
  - units: seg_n=10 (9), an_n=110
  - tens: seg_n=40 (without macro) or 7F (with macro), an_n=101
  - sign: seg_n=3F, an_n=011
- in_valid with in_result=5'b1_0000, in_negative=1, in_zero=1 -> sign digit blank (7F), units seg_n=40; "-0" is never shown.
- in_result=5'b0_1111 (15), in_negative=0 -> tens seg_n=79 (1), units seg_n=12 (5), sign 7F.
- in_valid pulsed on the same edge as a counter wrap, then again on the next cycle with a different value -> the second value is displayed from the following edge; no glitch value persists beyond one cycle.
- rst asserted asynchronously mid-digit (between clk edges) -> an_n=111 and seg_n=7F before the next clk edge; after release, disp_valid=0 until the next in_valid.
